// File: rtl/ame_sobel_grad.sv
// Sobel/Scharr gradient engine for the AME front end: consumes one (BLK_SIZE+2)-pixel
// column per accepted cycle and emits a saturated BLK_SIZE x BLK_SIZE signed gradient block.
module ame_sobel_grad #(
    parameter int BLK_SIZE       = 4,
    parameter int LINE_DATA_BITS = 7,
    parameter int COMP_DATA_BITS = 12
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic                                          comp_init_i,
    input  logic                                          kern_sel_i,
    input  logic                                          line_vld_i,
    input  logic [(BLK_SIZE+2)*LINE_DATA_BITS-1:0]        line_data_i,
    output logic                                          comp_busy_o,
    output logic                                          comp_done_o,
    output logic [BLK_SIZE*BLK_SIZE*COMP_DATA_BITS-1:0]   comp_data_o
);

    localparam int NCOL  = BLK_SIZE + 2;
    localparam int CNT_W = $clog2(NCOL);
    localparam int ACC_W = LINE_DATA_BITS + 5;
    localparam int SAT_W = ((ACC_W > COMP_DATA_BITS) ? ACC_W : COMP_DATA_BITS) + 1;
    localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'((64'sd1 <<< (COMP_DATA_BITS - 1)) - 64'sd1);
    localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          col_q;
    logic                      kern_q;
    logic signed [ACC_W-1:0]   acc_q [BLK_SIZE][BLK_SIZE];
    logic signed [ACC_W-1:0]   acc_d [BLK_SIZE][BLK_SIZE];
    logic [ACC_W-1:0]          colsum_s [BLK_SIZE];
    logic [ACC_W-1:0]          w0_s;
    logic [ACC_W-1:0]          w1_s;
    logic                      accept_s;
    logic                      last_s;

    function automatic logic [COMP_DATA_BITS-1:0] sat_f(input logic signed [ACC_W-1:0] v);
        logic signed [SAT_W-1:0] ve;
        ve = {{(SAT_W-ACC_W){v[ACC_W-1]}}, v};
        if (ve > SAT_MAX) begin
            return SAT_MAX[COMP_DATA_BITS-1:0];
        end else if (ve < SAT_MIN) begin
            return SAT_MIN[COMP_DATA_BITS-1:0];
        end else begin
            return ve[COMP_DATA_BITS-1:0];
        end
    endfunction

    assign w0_s     = kern_q ? ACC_W'(4'd3)  : ACC_W'(4'd1);
    assign w1_s     = kern_q ? ACC_W'(4'd10) : ACC_W'(4'd2);
    assign accept_s = (state_q == ST_RUN) && line_vld_i;
    assign last_s   = (col_q == CNT_W'(NCOL - 1));

    // Vertical 3-tap smoothing of the incoming column, one sum per output row.
    always_comb begin
        for (int r = 0; r < BLK_SIZE; r++) begin
            colsum_s[r] = w0_s * ACC_W'(line_data_i[r*LINE_DATA_BITS +: LINE_DATA_BITS])
                        + w1_s * ACC_W'(line_data_i[(r+1)*LINE_DATA_BITS +: LINE_DATA_BITS])
                        + w0_s * ACC_W'(line_data_i[(r+2)*LINE_DATA_BITS +: LINE_DATA_BITS]);
        end
    end

    // Horizontal difference: column c opens output c with -s and closes output c-2 with +s.
    always_comb begin
        for (int r = 0; r < BLK_SIZE; r++) begin
            for (int j = 0; j < BLK_SIZE; j++) begin
                acc_d[r][j] = acc_q[r][j];
                if (accept_s && (int'(col_q) == j)) begin
                    acc_d[r][j] = -$signed(colsum_s[r]);
                end else if (accept_s && (int'(col_q) == j + 2)) begin
                    acc_d[r][j] = acc_q[r][j] + $signed(colsum_s[r]);
                end else begin
                    acc_d[r][j] = acc_q[r][j];
                end
            end
        end
    end

    // Control FSM, column counter, accumulators and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            kern_q      <= 1'b0;
            comp_busy_o <= 1'b0;
            comp_done_o <= 1'b0;
            comp_data_o <= '0;
            for (int r = 0; r < BLK_SIZE; r++) begin
                for (int j = 0; j < BLK_SIZE; j++) begin
                    acc_q[r][j] <= '0;
                end
            end
        end else begin
            acc_q <= acc_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    comp_done_o <= 1'b0;
                    if (comp_init_i) begin
                        state_q     <= ST_RUN;
                        comp_busy_o <= 1'b1;
                        col_q       <= '0;
                        kern_q      <= kern_sel_i;
                    end else begin
                        state_q     <= ST_IDLE;
                        comp_busy_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept_s && last_s) begin
                        state_q     <= ST_DONE;
                        comp_busy_o <= 1'b0;
                        comp_done_o <= 1'b1;
                        for (int r = 0; r < BLK_SIZE; r++) begin
                            for (int j = 0; j < BLK_SIZE; j++) begin
                                comp_data_o[(r*BLK_SIZE+j)*COMP_DATA_BITS +: COMP_DATA_BITS] <= sat_f(acc_d[r][j]);
                            end
                        end
                    end else if (accept_s) begin
                        col_q <= col_q + CNT_W'(1'b1);
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    comp_busy_o <= 1'b0;
                    comp_done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ame_sobel_grad.sv
// Directed bench for ame_sobel_grad: a 12-bit and an 8-bit (saturating) instance share stimulus;
// expected blocks come from a direct 2-D Sobel/Scharr model pushed to a scoreboard at block start.
module tb_ame_sobel_grad;

    localparam int BLK  = 4;
    localparam int LDB  = 7;
    localparam int NCOL = BLK + 2;
    localparam int LW   = NCOL * LDB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n, init, kern_sel, vld;
    logic [LW-1:0]          ldata;
    logic                   busy12, done12, busy8, done8;
    logic [BLK*BLK*12-1:0]  data12;
    logic [BLK*BLK*8-1:0]   data8;

    ame_sobel_grad #(.BLK_SIZE(BLK), .LINE_DATA_BITS(LDB), .COMP_DATA_BITS(12)) u_dut12 (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .kern_sel_i(kern_sel),
        .line_vld_i(vld), .line_data_i(ldata),
        .comp_busy_o(busy12), .comp_done_o(done12), .comp_data_o(data12));

    ame_sobel_grad #(.BLK_SIZE(BLK), .LINE_DATA_BITS(LDB), .COMP_DATA_BITS(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .kern_sel_i(kern_sel),
        .line_vld_i(vld), .line_data_i(ldata),
        .comp_busy_o(busy8), .comp_done_o(done8), .comp_data_o(data8));

    int           n_vec = 0;
    int           n_err = 0;
    logic [6:0]   pix [NCOL][NCOL];
    logic [255:0] exp12_q[$];
    logic [255:0] exp8_q[$];
    logic [255:0] held12, held8;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int csum(input bit k, input int c, input int r);
        int w0, w1;
        w0 = k ? 3 : 1;
        w1 = k ? 10 : 2;
        return w0 * int'(pix[c][r]) + w1 * int'(pix[c][r+1]) + w0 * int'(pix[c][r+2]);
    endfunction

    function automatic logic [255:0] model(input bit k, input int w);
        logic [255:0] v;
        int g, hi, lo;
        v  = '0;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        for (int r = 0; r < BLK; r++) begin
            for (int j = 0; j < BLK; j++) begin
                g = csum(k, j + 2, r) - csum(k, j, r);
                if (g > hi) g = hi;
                if (g < lo) g = lo;
                for (int b = 0; b < w; b++) v[(r*BLK+j)*w + b] = g[b];
            end
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] col_vec(input int c);
        logic [LW-1:0] v;
        for (int r = 0; r < NCOL; r++) v[r*LDB +: LDB] = pix[c][r];
        return v;
    endfunction

    task automatic set_img(input int mode, input int val);
        for (int c = 0; c < NCOL; c++) begin
            for (int r = 0; r < NCOL; r++) begin
                case (mode)
                    0: pix[c][r] = 7'(val);
                    1: pix[c][r] = 7'(10 * c);
                    2: pix[c][r] = (c >= 2) ? 7'd127 : 7'd0;
                    3: pix[c][r] = (c < 2) ? 7'd127 : 7'd0;
                    default: pix[c][r] = 7'($urandom_range(0, 127));
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_blk(input bit k);
        exp12_q.push_back(model(k, 12));
        exp8_q.push_back(model(k, 8));
    endtask

    task automatic start(input bit k);
        init     = 1'b1;
        kern_sel = k;
        vld      = 1'b0;
        chk("busy_at_init", 256'({busy12, busy8}), 256'(2'b00));
        expect_blk(k);
    endtask

    // Runs from the init cycle to the done cycle; kern_sel is flipped to prove it was latched.
    task automatic feed(input bit k, input int stall_at, input int stall_n, input bit hold_init);
        logic [255:0] e12, e8;
        tick();
        if (!hold_init) init = 1'b0;
        kern_sel = ~k;
        for (int c = 0; c < NCOL; c++) begin
            if (c == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    vld   = 1'b0;
                    ldata = LW'({$urandom(), $urandom()});
                    chk("busy_stall", 256'({busy12, busy8, done12, done8}), 256'(4'b1100));
                    tick();
                end
            end
            vld   = 1'b1;
            ldata = col_vec(c);
            chk("busy_run", 256'({busy12, busy8, done12, done8}), 256'(4'b1100));
            chk("held12", 256'(data12), held12);
            chk("held8", 256'(data8), held8);
            tick();
        end
        vld = 1'b0;
        chk("done_pulse", 256'({busy12, busy8, done12, done8}), 256'(4'b0011));
        e12 = exp12_q.pop_front();
        e8  = exp8_q.pop_front();
        chk("data12", 256'(data12), e12);
        chk("data8", 256'(data8), e8);
        held12 = e12;
        held8  = e8;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            init = 1'b0;
            vld  = 1'b0;
            tick();
            chk("idle_ctrl", 256'({busy12, busy8, done12, done8}), 256'(4'b0000));
            chk("idle_hold12", 256'(data12), held12);
            chk("idle_hold8", 256'(data8), held8);
        end
    endtask

    initial begin
        rst_n = 1'b0; init = 1'b0; kern_sel = 1'b0; vld = 1'b0; ldata = '0;
        held12 = '0; held8 = '0;
        tick(); tick();
        chk("reset_ctrl", 256'({busy12, busy8, done12, done8}), 256'(4'b0000));
        chk("reset_data12", 256'(data12), 256'(1'b0));
        chk("reset_data8", 256'(data8), 256'(1'b0));
        rst_n = 1'b1;
        idle(1);

        // Line data while idle must be ignored.
        vld = 1'b1; ldata = LW'({$urandom(), $urandom()});
        tick(); tick();
        chk("idle_vld_ignored", 256'({busy12, busy8, done12, done8}), 256'(4'b0000));

        set_img(0, 55); start(1'b0); feed(1'b0, -1, 0, 1'b0); idle(2);
        set_img(1, 0);  start(1'b0); feed(1'b0, -1, 0, 1'b0); idle(1);
        set_img(1, 0);  start(1'b1); feed(1'b1, -1, 0, 1'b0); idle(1);
        set_img(1, 0);  start(1'b0); feed(1'b0, 3, 3, 1'b0);  idle(1);
        set_img(4, 0);  start(1'b1); feed(1'b1, 2, 1, 1'b0);  idle(1);
        set_img(4, 0);  start(1'b0); feed(1'b0, 5, 2, 1'b0);  idle(1);

        // Back-to-back: init held through the first block's done cycle.
        set_img(1, 0);  start(1'b0); feed(1'b0, -1, 0, 1'b1);
        kern_sel = 1'b0;
        set_img(0, 55); expect_blk(1'b0);
        feed(1'b0, -1, 0, 1'b0); idle(1);

        set_img(2, 0);  start(1'b0); feed(1'b0, -1, 0, 1'b0); idle(1);
        set_img(3, 0);  start(1'b0); feed(1'b0, -1, 0, 1'b0); idle(1);

        // Reset at column 3 of a ramp block: abort, outputs cleared, no done.
        set_img(1, 0);
        init = 1'b1; kern_sel = 1'b0; vld = 1'b0;
        tick();
        init = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vld = 1'b1; ldata = col_vec(c);
            tick();
        end
        vld = 1'b1; ldata = col_vec(3); rst_n = 1'b0;
        tick();
        chk("rst_mid_ctrl", 256'({busy12, busy8, done12, done8}), 256'(4'b0000));
        chk("rst_mid_data12", 256'(data12), 256'(1'b0));
        chk("rst_mid_data8", 256'(data8), 256'(1'b0));
        held12 = '0; held8 = '0;
        rst_n = 1'b1;
        for (int c = 4; c < NCOL; c++) begin
            vld = 1'b1; ldata = col_vec(c);
            tick();
            chk("rst_no_done", 256'({busy12, busy8, done12, done8}), 256'(4'b0000));
        end
        idle(3);
        start(1'b0); feed(1'b0, -1, 0, 1'b0); idle(1);

        chk("scoreboard_empty", 256'(exp12_q.size() + exp8_q.size()), 256'(1'b0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ame_sobel_grad.md
# ame_sobel_grad

Parametrised Sobel/Scharr gradient engine for the affine motion estimation (AME) front end. It accepts one (BLK_SIZE+2)-pixel line per cycle from the line buffer; the vertical memory feeds the horizontal filter and the horizontal memory feeds the vertical filter. It produces a BLK_SIZE x BLK_SIZE block of signed gradients. Compared with the fixed 4x4 engine, it adds:
- configurable block size;
- a runtime kernel select (Sobel/Scharr);
- input-valid stalling;
- saturating output;
- outputs held stable between blocks.

## Interface
- BLK_SIZE, 4, output block edge in pixels; legal range ≥ 2.
- LINE_DATA_BITS, 7, unsigned input pixel width.
- COMP_DATA_BITS, 12, signed output width; narrower widths saturate.
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- comp_init_i  in  1  start a block; sampled in IDLE or DONE only.
- kern_sel_i  in  1  0 = Sobel (1,2,1), 1 = Scharr (3,10,3); latched when comp_init_i is accepted.
- line_vld_i  in  1  line_data_i carries a valid column this cycle.
- line_data_i  in  (BLK_SIZE+2)×LINE_DATA_BITS  one column of pixels p[0..BLK_SIZE+1].
- comp_busy_o  out  1  high while in RUN.
- comp_done_o  out  1  one-cycle pulse; comp_data_o is updated in this same cycle.
- comp_data_o  out  BLK_SIZE×BLK_SIZE×COMP_DATA_BITS  [row][col] signed gradients.

## Operation
- States:
  - IDLE -> RUN on comp_init_i.
  - RUN -> DONE the cycle after column BLK_SIZE+1 is accepted.
  - DONE -> RUN if comp_init_i, else IDLE.
  - Undefined state -> IDLE.
- Column counter c runs 0..BLK_SIZE+1, width clog2(BLK_SIZE+2). It increments only on RUN && line_vld_i, and clears on block start.
- Weights: (w0, w1) = (1, 2) for Sobel, (3, 10) for Scharr.
- Per accepted column, for each row r: s[r] = w0·p[r] + w1·p[r+1] + w0·p[r+2], unsigned.
- Internal accumulators acc[r][j] are signed, width LINE_DATA_BITS+5; no overflow is possible inside them. On each accepted column c:
  - if c < BLK_SIZE: acc[r][c] <= −s[r];
  - if c ≥ 2: acc[r][c−2] <= acc[r][c−2] + s[r];
  - both updates happen in the same cycle when both apply (different j).
- Result: comp_data_o[r][j] = s(column j+2) − s(column j).
- On entry to DONE, comp_data_o <= sat(acc), clamped to [−2^(COMP_DATA_BITS−1), 2^(COMP_DATA_BITS−1)−1].
- comp_data_o holds its value until the next DONE; IDLE does not clear it.
- Inputs are ignored while not in RUN. comp_init_i during RUN is ignored. kern_sel_i changes during RUN have no effect.
- line_vld_i low in RUN stalls the engine: counter and accumulators hold, with no timeout.

## Timing
- Reset values: comp_busy_o=0, comp_done_o=0, comp_data_o=0, state IDLE, counter 0, accumulators 0.
- A sync reset mid-block aborts it: no done pulse, outputs return to 0.
- comp_init_i seen at cycle t moves the state to RUN at t+1. The first column can be accepted at t+1.
- With line_vld_i held high, columns are accepted at t+1..t+BLK_SIZE+2, and comp_done_o plus new comp_data_o appear at t+BLK_SIZE+3.
- Each stalled cycle adds exactly one cycle of latency.
- Back-to-back blocks: comp_init_i high in the DONE cycle gives RUN the next cycle, so the period is BLK_SIZE+3 cycles.
- comp_busy_o is high exactly during RUN cycles. It is low in the DONE cycle.
- comp_done_o is high for exactly one cycle per completed block.

## Test plan
- Flat image, Sobel (BLK_SIZE=4, every pixel 55, line_vld_i high) -> all 16 outputs 0; done at t+7; busy high t+1..t+6.
- Horizontal ramp (column c pixels = 10·c):
  - Sobel -> all outputs 80;
  - repeat with kern_sel_i=1 -> all outputs 320.
- Stall: same ramp with line_vld_i low for 3 cycles after column 2 -> identical outputs 80; done at t+10.
- Saturation, COMP_DATA_BITS=8:
  - columns 0,1 = 0 and columns 2..5 = 127 -> output cols 0,1 = 127 (clamped from 508), cols 2,3 = 0;
  - mirrored input -> cols 0,1 = −128.
- Back-to-back: init held through two blocks (ramp, then flat) -> done pulses 7 cycles apart; outputs 80, then 0; outputs stay at 80 between the two done pulses.
- Reset mid-op: assert rst_n_i low at column 3 -> next cycle outputs 0, busy 0, no done pulse; a fresh ramp block then yields 80.
